// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_arbiter
// Purpose  : Round-robin two-master arbiter for a single-port on-chip RAM
//            with latency-1 tagged read return and out-of-range fault capture.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4,
   parameter int DEPTH  = 51200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              err_valid,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_master,
   input  logic              err_clear
);

   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

   logic              w_req0, w_req1;
   logic              w_grant0, w_grant1, w_grant_any;
   logic              w_sel_read, w_sel_write;
   logic              w_in_range, w_fault;
   logic [ADDR_W-1:0] w_addr;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;

   logic              r_last_grant;
   logic              r_rd_pend, r_rd_id, r_rd_oor;
   logic              r_err_valid, r_err_master;
   logic [ADDR_W-1:0] r_err_addr;

   assign w_req0      = m0_read | m0_write;
   assign w_req1      = m1_read | m1_write;
   // Under contention the master that did not win last time is served.
   assign w_grant0    = w_req0 & (~w_req1 | r_last_grant);
   assign w_grant1    = w_req1 & (~w_req0 | ~r_last_grant);
   assign w_grant_any = w_grant0 | w_grant1;

   always_comb begin
      w_addr      = '0;
      w_be        = '0;
      w_wdata     = '0;
      w_sel_read  = 1'b0;
      w_sel_write = 1'b0;
      if (w_grant0) begin
         w_addr      = m0_address;
         w_be        = m0_byteenable;
         w_wdata     = m0_writedata;
         w_sel_read  = m0_read;
         w_sel_write = m0_write;
      end else if (w_grant1) begin
         w_addr      = m1_address;
         w_be        = m1_byteenable;
         w_wdata     = m1_writedata;
         w_sel_read  = m1_read;
         w_sel_write = m1_write;
      end
   end

   assign w_in_range = ({1'b0, w_addr} < c_depth);
   assign w_fault    = w_grant_any & ~w_in_range;

   assign m0_waitrequest = reset | (w_req0 & ~w_grant0);
   assign m1_waitrequest = reset | (w_req1 & ~w_grant1);

   assign mem_address    = w_addr;
   assign mem_byteenable = w_be;
   assign mem_writedata  = w_wdata;
   assign mem_chipselect = ~reset & w_grant_any & w_in_range;
   assign mem_write      = ~reset & w_sel_write & w_in_range;
   assign mem_clken      = ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_rd_pend    <= 1'b0;
         r_rd_id      <= 1'b0;
         r_rd_oor     <= 1'b0;
      end else begin
         if (w_grant_any) begin
            r_last_grant <= w_grant1;
         end
         r_rd_pend <= w_sel_read;
         if (w_sel_read) begin
            r_rd_id  <= w_grant1;
            r_rd_oor <= ~w_in_range;
         end
      end
   end

   // A fault coinciding with a clear is captured rather than lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_valid  <= 1'b0;
         r_err_addr   <= '0;
         r_err_master <= 1'b0;
      end else if (w_fault && (!r_err_valid || err_clear)) begin
         r_err_valid  <= 1'b1;
         r_err_addr   <= w_addr;
         r_err_master <= w_grant1;
      end else if (err_clear) begin
         r_err_valid  <= 1'b0;
         r_err_addr   <= '0;
         r_err_master <= 1'b0;
      end
   end

   assign w_rdata          = r_rd_oor ? '0 : mem_readdata;
   assign m0_readdata      = w_rdata;
   assign m1_readdata      = w_rdata;
   assign m0_readdatavalid = r_rd_pend & ~r_rd_id;
   assign m1_readdatavalid = r_rd_pend & r_rd_id;

   assign err_valid  = r_err_valid;
   assign err_addr   = r_err_addr;
   assign err_master = r_err_master;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_arbiter
// Purpose  : Directed and randomized self-checking bench for onchip_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_arbiter;

   localparam int DEPTH = 51200;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [15:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [15:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_readdata;
   logic        err_valid, err_master, err_clear;
   logic [15:0] err_addr;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .BE_W(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
      .err_valid(err_valid), .err_addr(err_addr), .err_master(err_master),
      .err_clear(err_clear)
   );

   // RAM environment: full 64K array so a wrongly issued out-of-range write is visible.
   logic [31:0] ram [0:65535];
   logic [15:0] ram_addr_q = 16'h0;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [31:0] ld_data;

   always @(posedge clk) begin
      if (ld_en) begin
         ram[ld_addr] <= ld_data;
      end else if (mem_clken && mem_chipselect) begin
         ram_addr_q <= mem_address;
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end
      end
   end
   assign mem_readdata = ram[ram_addr_q];

   // Reference model state
   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_mem [0:DEPTH-1];
   int          m_last, m_pid;
   bit          m_pend;
   logic [31:0] m_pdata;
   bit          e_valid, e_master;
   logic [15:0] e_addr;
   int          cur_g;
   bit          cur_rd, cur_wr, cur_inr, exp_w0, exp_w1;
   logic [15:0] cur_a;
   logic [3:0]  cur_be;
   logic [31:0] cur_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, req_v, $time);
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic sample();
      bit r0, r1;
      @(negedge clk);
      if (reset) begin
         cur_g = -1; exp_w0 = 0; exp_w1 = 0;
         chk("rst_wait0", m0_waitrequest, 1);
         chk("rst_wait1", m1_waitrequest, 1);
         chk("rst_cs", mem_chipselect, 0);
         chk("rst_we", mem_write, 0);
         chk("rst_clken", mem_clken, 0);
         chk("rst_valid0", m0_readdatavalid, 0);
         chk("rst_valid1", m1_readdatavalid, 0);
         chk("rst_err_valid", err_valid, 0);
         chk("rst_err_addr", err_addr, 0);
         chk("rst_err_master", err_master, 0);
         return;
      end
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      if (r0 && r1) cur_g = (m_last == 0) ? 1 : 0;
      else if (r0)  cur_g = 0;
      else if (r1)  cur_g = 1;
      else          cur_g = -1;
      cur_a = 0; cur_be = 0; cur_wd = 0; cur_rd = 0; cur_wr = 0;
      if (cur_g == 0) begin
         cur_a = m0_address; cur_be = m0_byteenable; cur_wd = m0_writedata;
         cur_rd = m0_read; cur_wr = m0_write;
      end else if (cur_g == 1) begin
         cur_a = m1_address; cur_be = m1_byteenable; cur_wd = m1_writedata;
         cur_rd = m1_read; cur_wr = m1_write;
      end
      cur_inr = (int'(cur_a) < DEPTH);
      exp_w0 = r0 && cur_g != 0;
      exp_w1 = r1 && cur_g != 1;
      chk("wait0", m0_waitrequest, exp_w0);
      chk("wait1", m1_waitrequest, exp_w1);
      chk("mem_address", mem_address, cur_a);
      chk("mem_byteenable", mem_byteenable, cur_be);
      chk("mem_writedata", mem_writedata, cur_wd);
      chk("mem_chipselect", mem_chipselect, cur_g >= 0 && cur_inr);
      chk("mem_write", mem_write, cur_g >= 0 && cur_wr && cur_inr);
      chk("mem_clken", mem_clken, 1);
      chk("valid0", m0_readdatavalid, m_pend && m_pid == 0);
      chk("valid1", m1_readdatavalid, m_pend && m_pid == 1);
      if (m_pend) begin
         chk("readdata0", m0_readdata, m_pdata);
         chk("readdata1", m1_readdata, m_pdata);
      end
      chk("err_valid", err_valid, e_valid);
      chk("err_addr", err_addr, e_addr);
      chk("err_master", err_master, e_master);
   endtask

   // Apply the effect of the coming clock edge to the model, then cross it.
   task automatic advance();
      if (reset) begin
         m_last = 1; m_pend = 0; m_pid = 0;
         e_valid = 0; e_addr = 0; e_master = 0;
      end else begin
         if (cur_g >= 0) m_last = cur_g;
         if (cur_g >= 0 && cur_wr && cur_inr)
            for (int b = 0; b < 4; b++)
               if (cur_be[b]) model_mem[cur_a][8*b +: 8] = cur_wd[8*b +: 8];
         m_pend = (cur_g >= 0) && cur_rd;
         if (m_pend) begin
            m_pid   = cur_g;
            m_pdata = cur_inr ? model_mem[cur_a] : 32'h0;
         end
         if (cur_g >= 0 && !cur_inr && (!e_valid || err_clear)) begin
            e_valid = 1; e_addr = cur_a; e_master = (cur_g == 1);
         end else if (err_clear) begin
            e_valid = 0; e_addr = 0; e_master = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; err_clear = 0;
   endtask

   task automatic load(input logic [15:0] a, input logic [31:0] d);
      ld_en = 1; ld_addr = a; ld_data = d;
      if (int'(a) < DEPTH) model_mem[a] = d;
      tick();
      ld_en = 0;
   endtask

   function automatic logic [15:0] rand_addr();
      int r = $urandom_range(0, 19);
      if (r < 14) return 16'($urandom_range(0, 63));
      case (r)
         14:      return 16'h0100;
         15:      return 16'(DEPTH - 1);
         16:      return 16'hC800;
         17:      return 16'hD000;
         default: return 16'hFFFF;
      endcase
   endfunction

   task automatic rand_master(output logic rd, output logic wr, output logic [15:0] a,
                              output logic [3:0] be, output logic [31:0] wd);
      int k = $urandom_range(0, 3);
      rd = (k == 1 || k == 3);
      wr = (k == 2);
      a  = rand_addr();
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
   endtask

   initial begin
      reset = 1; ld_en = 0; ld_addr = 0; ld_data = 0;
      idle();
      m0_address = 0; m1_address = 0; m0_byteenable = 0; m1_byteenable = 0;
      m0_writedata = 0; m1_writedata = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      @(posedge clk); #1;

      // Preload while reset holds the arbiter; a request must still see waitrequest.
      m0_read = 1;
      sample();
      chk("lit_rst_wait0", m0_waitrequest, 1);
      advance();
      idle();
      for (int i = 0; i < 64; i++) load(16'(i), $urandom);
      load(16'h0010, 32'hDEADBEEF);
      load(16'h0100, 32'hAAAAAAAA);
      load(16'(DEPTH - 1), $urandom);
      load(16'hC800, 32'h5A5A0001);
      load(16'hD000, 32'h5A5A0002);
      load(16'hFFFF, 32'h5A5A0003);
      reset = 0;
      tick();

      // Continuous contention: m0 first, then strict alternation.
      m0_read = 1; m0_address = 16'h0020;
      m1_read = 1; m1_address = 16'h0021;
      for (int i = 0; i < 6; i++) begin
         sample();
         chk("lit_cont_wait0", m0_waitrequest, (i % 2) == 1);
         chk("lit_cont_wait1", m1_waitrequest, (i % 2) == 0);
         if (i > 0) chk("lit_cont_valid0", m0_readdatavalid, (i % 2) == 1);
         advance();
      end
      idle();
      tick();

      // Single read of a preloaded word.
      m0_read = 1; m0_address = 16'h0010;
      sample();
      chk("lit_rd_nowait", m0_waitrequest, 0);
      advance();
      idle();
      sample();
      chk("lit_rd_valid0", m0_readdatavalid, 1);
      chk("lit_rd_data", m0_readdata, 32'hDEADBEEF);
      chk("lit_rd_valid1", m1_readdatavalid, 0);
      advance();

      // Partial write then read-back.
      m1_write = 1; m1_address = 16'h0100; m1_byteenable = 4'b0011; m1_writedata = 32'h12345678;
      tick();
      idle();
      m0_read = 1; m0_address = 16'h0100;
      tick();
      idle();
      sample();
      chk("lit_be_data", m0_readdata, 32'hAAAA5678);
      advance();

      // Out-of-range write, then out-of-range read.
      m0_write = 1; m0_address = 16'hC800; m0_byteenable = 4'hF; m0_writedata = 32'hFFFFFFFF;
      sample();
      chk("lit_oor_cs", mem_chipselect, 0);
      advance();
      idle();
      chk("lit_oor_err_valid", err_valid, 1);
      chk("lit_oor_err_addr", err_addr, 16'hC800);
      chk("lit_oor_err_master", err_master, 0);
      chk("lit_oor_ram", ram[16'hC800], 32'h5A5A0001);
      m1_read = 1; m1_address = 16'hFFFF;
      tick();
      idle();
      sample();
      chk("lit_oor_valid1", m1_readdatavalid, 1);
      chk("lit_oor_rdata", m1_readdata, 32'h0);
      chk("lit_oor_keep_addr", err_addr, 16'hC800);
      advance();

      // Clear coinciding with a new fault: the fault is captured.
      m1_read = 1; m1_address = 16'hD000; err_clear = 1;
      tick();
      idle();
      sample();
      chk("lit_clr_valid", err_valid, 1);
      chk("lit_clr_addr", err_addr, 16'hD000);
      chk("lit_clr_master", err_master, 1);
      advance();
      err_clear = 1;
      tick();
      idle();

      // Reset right after a granted read discards the beat.
      m1_read = 1; m1_address = 16'h0020;
      tick();
      idle();
      reset = 1;
      sample();
      chk("lit_rstrd_valid1", m1_readdatavalid, 0);
      advance();
      reset = 0;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("lit_rstrd_after", m1_readdatavalid, 0);
         advance();
      end
      m0_read = 1; m0_address = 16'h0001;
      m1_read = 1; m1_address = 16'h0002;
      sample();
      chk("lit_rst_first_w0", m0_waitrequest, 0);
      chk("lit_rst_first_w1", m1_waitrequest, 1);
      advance();
      idle();

      // Randomized traffic; a stalled master holds its request.
      for (int n = 0; n < 3000; n++) begin
         if (!exp_w0) rand_master(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
         if (!exp_w1) rand_master(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
         err_clear = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 0;
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master arbiter in front of the 51200 x 32-bit single-port on-chip RAM. The RAM has a registered address and unregistered output, so read latency is 1.
- Shares the RAM between the Nios II data master (m0) and a DMA/pixel master (m1) using round-robin, one access per cycle.
- Returns read data through a pipelined readdatavalid path tagged with the requester.
- Blocks out-of-range addresses and records the first faulting address.

Parameters:
- ADDR_W, 16, word-address width for masters and the RAM.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- DEPTH, 51200, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_read, m0_write  in  1 each  m0 request strobes; never both high together.
- m0_address  in  ADDR_W  m0 word address.
- m0_byteenable  in  BE_W  m0 byte lanes.
- m0_writedata  in  DATA_W  m0 write data.
- m0_waitrequest  out  1  m0 request not accepted this cycle.
- m0_readdata  out  DATA_W  m0 read data.
- m0_readdatavalid  out  1  m0 read data valid.
- m1_*  same set as m0, for master 1.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  BE_W  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_clken  out  1  to RAM clock enable.
- mem_readdata  in  DATA_W  from RAM.
- err_valid  out  1  sticky out-of-range flag.
- err_addr  out  ADDR_W  first faulting address.
- err_master  out  1  master that caused the first fault.
- err_clear  in  1  clears err_valid, err_addr and err_master.

Behaviour:
- Reset (async, active-high):
  - last_grant=1, so m0 wins the first contention.
  - rd_pend=0, rd_id=0, rd_oor=0.
  - err_valid=0, err_addr=0, err_master=0.
  - All readdatavalid=0.
  - Both waitrequests=1 while reset is high.
  - mem_chipselect=0, mem_write=0, mem_clken=0 while reset is high.
  - Reset mid-read discards the pending beat: no readdatavalid after reset deasserts.
- reqN = mN_read | mN_write.
- Grant (combinational from registered last_grant):
  - Only one master requests: it is granted.
  - Both request: the master != last_grant is granted.
  - Neither requests: no grant; last_grant holds.
  - last_grant updates at the edge to the granted index.
- Waitrequest: mN_waitrequest = reqN & ~grantN. An idle master sees 0. The losing master holds its signals, and Avalon rules guarantee it wins next cycle, so wait is at most 1 cycle under continuous contention.
- Memory side:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master; all zero when none granted.
  - mem_chipselect = grant_any & in_range.
  - mem_write = granted write & in_range.
  - mem_clken = ~reset.
  - in_range = (granted address < DEPTH), unsigned compare.
- Read pipeline, latency 1:
  - At the edge of a granted read: rd_pend<=1, rd_id<=index, rd_oor<=~in_range. Otherwise rd_pend<=0.
  - m{rd_id}_readdatavalid = rd_pend.
  - Readdata = rd_oor ? 0 : mem_readdata, presented to both masters; only the valid flag is routed.
  - Back-to-back reads (one per cycle, alternating masters) produce a valid every cycle.
- Writes: complete in the grant cycle. No response.
- Out-of-range writes are dropped and the RAM is not touched. Out-of-range reads still return a valid beat with data 0x00000000.
- Error capture:
  - On a granted out-of-range access while err_valid=0: err_valid<=1, err_addr<=address, err_master<=index.
  - Later faults do not overwrite the capture.
  - err_clear clears all three at the edge.
  - err_clear and a new fault in the same cycle: the fault wins (captured, err_valid=1).
- Simultaneous read of one master and write of the other: one is granted; the other waits 1 cycle. Read-during-write to the same address is impossible because access is single-port, one per cycle.

Test Plan:
- Reset, then m0 read addr 0x0010 (RAM holds 0xDEADBEEF): no wait; m0_readdatavalid=1 one cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both hold reads continuously for 6 cycles: grants m0,m1,m0,m1,m0,m1; each waitrequest high exactly on alternate cycles; valids routed alternately with correct data.
- m1 write 0x12345678 to 0x0100 with byteenable 4'b0011, then m0 reads 0x0100 (prior content 0xAAAAAAAA): returns 0xAAAA5678.
- m0 write to 0xC800 (51200): mem_chipselect=0 and RAM unchanged; err_valid=1, err_addr=0xC800, err_master=0. A following m1 read of 0xFFFF returns 0 with a valid beat; err_addr stays 0xC800.
- err_clear pulsed in the same cycle as a new fault at 0xD000 by m1: err_valid=1, err_addr=0xD000, err_master=1.
- Assert reset the cycle after a granted m1 read: no m1_readdatavalid ever appears. After release, first contention grants m0.
